// File: rtl/reorder_buffer_if.sv
// Bundle between the rename/dispatch side, the CDB and the commit side of the reorder buffer.
// The ROB takes the slave modport; the core (or a bench) drives it through master.
interface reorder_buffer_if #(
  parameter int ROB_BIT   = 4,
  parameter int REG_BIT   = 5,
  parameter int DAT_W     = 32,
  parameter int RAM_ADR_W = 32
);
  logic                 flush_i;
  logic                 dp_en_i;
  logic [REG_BIT-1:0]   dp_rd_i;
  logic                 dp_wr_i;
  logic                 dp_st_i;
  logic [RAM_ADR_W-1:0] dp_pc_i;
  logic [ROB_BIT-1:0]   qd_o;
  logic                 full_o;
  logic                 empty_o;
  logic                 cdb_en_i;
  logic [ROB_BIT-1:0]   cdb_q_i;
  logic [DAT_W-1:0]     cdb_v_i;
  logic [ROB_BIT-1:0]   qry_j_i;
  logic [ROB_BIT-1:0]   qry_k_i;
  logic                 rdy_j_o;
  logic [DAT_W-1:0]     val_j_o;
  logic                 rdy_k_o;
  logic [DAT_W-1:0]     val_k_o;
  logic                 cm_en_o;
  logic [REG_BIT-1:0]   cm_rd_o;
  logic [ROB_BIT-1:0]   cm_q_o;
  logic [DAT_W-1:0]     cm_v_o;
  logic                 st_cm_o;
  logic [ROB_BIT-1:0]   st_q_o;
  logic [RAM_ADR_W-1:0] cm_pc_o;

  modport master (
    output flush_i, dp_en_i, dp_rd_i, dp_wr_i, dp_st_i, dp_pc_i,
    output cdb_en_i, cdb_q_i, cdb_v_i, qry_j_i, qry_k_i,
    input  qd_o, full_o, empty_o, rdy_j_o, val_j_o, rdy_k_o, val_k_o,
    input  cm_en_o, cm_rd_o, cm_q_o, cm_v_o, st_cm_o, st_q_o, cm_pc_o
  );

  modport slave (
    input  flush_i, dp_en_i, dp_rd_i, dp_wr_i, dp_st_i, dp_pc_i,
    input  cdb_en_i, cdb_q_i, cdb_v_i, qry_j_i, qry_k_i,
    output qd_o, full_o, empty_o, rdy_j_o, val_j_o, rdy_k_o, val_k_o,
    output cm_en_o, cm_rd_o, cm_q_o, cm_v_o, st_cm_o, st_q_o, cm_pc_o
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands out tags 1..DEPTH, captures CDB results and retires in order.
// Tag 0 means "no producer", so slot 0 of every table is never allocated.
module reorder_buffer #(
  parameter int ROB_BIT   = 4,
  parameter int REG_BIT   = 5,
  parameter int DAT_W     = 32,
  parameter int RAM_ADR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  reorder_buffer_if.slave  bus
);
  localparam int DEPTH = (1 << ROB_BIT) - 1;
  localparam logic [ROB_BIT-1:0] ONE  = ROB_BIT'(1);
  localparam logic [ROB_BIT-1:0] LAST = ROB_BIT'(DEPTH);

  logic [DEPTH:0]       busy;
  logic [DEPTH:0]       ready;
  logic [DEPTH:0]       wr;
  logic [DEPTH:0]       st;
  logic [REG_BIT-1:0]   rd_mem  [DEPTH+1];
  logic [DAT_W-1:0]     val_mem [DEPTH+1];
  logic [RAM_ADR_W-1:0] pc_mem  [DEPTH+1];

  logic [ROB_BIT-1:0]   head;
  logic [ROB_BIT-1:0]   tail;
  logic [ROB_BIT-1:0]   count;
  logic [ROB_BIT-1:0]   count_nxt;
  logic                 full;
  logic                 empty;
  logic                 do_dp;
  logic                 do_cm;
  logic                 do_cdb;

  logic                 cm_en;
  logic                 st_cm;
  logic [REG_BIT-1:0]   cm_rd;
  logic [ROB_BIT-1:0]   cm_q;
  logic [DAT_W-1:0]     cm_v;
  logic [ROB_BIT-1:0]   st_q;
  logic [RAM_ADR_W-1:0] cm_pc;

  function automatic logic [ROB_BIT-1:0] next_tag(input logic [ROB_BIT-1:0] t);
    return (t == LAST) ? ONE : t + ONE;
  endfunction

  // Tag 0 resolves first so a CDB carrying tag 0 can never bypass into a "no producer" operand.
  function automatic logic [DAT_W:0] lookup(input logic [ROB_BIT-1:0] q);
    if (q == '0)
      return {1'b1, {DAT_W{1'b0}}};
    else if (bus.cdb_en_i && bus.cdb_q_i == q)
      return {1'b1, bus.cdb_v_i};
    else
      return {ready[q], val_mem[q]};
  endfunction

  assign do_dp     = bus.dp_en_i && !full;
  assign do_cm     = busy[head] && ready[head];
  assign do_cdb    = bus.cdb_en_i && (bus.cdb_q_i != '0) && busy[bus.cdb_q_i];
  assign count_nxt = count + ROB_BIT'(do_dp) - ROB_BIT'(do_cm);

  always_comb begin
    {bus.rdy_j_o, bus.val_j_o} = lookup(bus.qry_j_i);
    {bus.rdy_k_o, bus.val_k_o} = lookup(bus.qry_k_i);
  end

  // Control state and commit port
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      ready <= '0;
      head  <= ONE;
      tail  <= ONE;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      cm_en <= 1'b0;
      st_cm <= 1'b0;
      cm_rd <= '0;
      cm_q  <= '0;
      cm_v  <= '0;
      st_q  <= '0;
      cm_pc <= '0;
    end else if (en) begin
      if (bus.flush_i) begin
        busy  <= '0;
        ready <= '0;
        head  <= ONE;
        tail  <= ONE;
        count <= '0;
        full  <= 1'b0;
        empty <= 1'b1;
        cm_en <= 1'b0;
        st_cm <= 1'b0;
      end else begin
        if (do_cdb)
          ready[bus.cdb_q_i] <= 1'b1;
        if (do_cm) begin
          busy[head] <= 1'b0;
          head       <= next_tag(head);
          cm_en      <= wr[head];
          st_cm      <= st[head];
          cm_rd      <= rd_mem[head];
          cm_q       <= head;
          cm_v       <= val_mem[head];
          st_q       <= head;
          cm_pc      <= pc_mem[head];
        end else begin
          cm_en <= 1'b0;
          st_cm <= 1'b0;
        end
        // Tail slot is never busy when dispatch fires, so this cannot collide with the CDB write.
        if (do_dp) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= next_tag(tail);
        end
        count <= count_nxt;
        full  <= (count_nxt == LAST);
        empty <= (count_nxt == '0);
      end
    end
  end

  // Entry payload
  always_ff @(posedge clk) begin
    if (en && !bus.flush_i) begin
      if (do_cdb)
        val_mem[bus.cdb_q_i] <= bus.cdb_v_i;
      if (do_dp) begin
        rd_mem[tail] <= bus.dp_rd_i;
        wr[tail]     <= bus.dp_wr_i;
        st[tail]     <= bus.dp_st_i;
        pc_mem[tail] <= bus.dp_pc_i;
      end
    end
  end

  assign bus.qd_o    = tail;
  assign bus.full_o  = full;
  assign bus.empty_o = empty;
  assign bus.cm_en_o = cm_en;
  assign bus.cm_rd_o = cm_rd;
  assign bus.cm_q_o  = cm_q;
  assign bus.cm_v_o  = cm_v;
  assign bus.st_cm_o = st_cm;
  assign bus.st_q_o  = st_q;
  assign bus.cm_pc_o = cm_pc;
endmodule
